n64rgb_igr: RTL and testbench
=============================

N64RGB_IGR -- requirements
Module: n64rgb_igr

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CLK_DIV, 6, VCLK cycles per sample tick; legal range 2..255
  WAIT_W, 6, width of the edge-interval counter; the idle threshold is 2^WAIT_W-1 ticks
  HOLD_POLLS, 2, consecutive matching polls needed to fire a combo; legal range 1..15
  RST_LEN, 18'h3ffff, DRV_RST pulse length in ticks
  IGR_RESET, 16'h0C0F, button word for the reset combo
  IGR_DEBLUR_ON, 16'h880C, button word for the deblur-on combo
  IGR_DEBLUR_OFF, 16'h480C, button word for the deblur-off combo
  IGR_15B_ON, 16'h180C, button word for the 15-bit-on combo
  IGR_15B_OFF, 16'h280C, button word for the 15-bit-off combo
REQ-002 Ports (name, direction, width, meaning):
  VCLK  in  1  sole clock
  RST  in  1  asynchronous, active-high reset
  CTRL_i  in  1  controller data line, asynchronous to VCLK
  n64_480i  in  1  interlaced video flag
  n15bit_mode_t  in  1  15-bit mode switch
  nVIDeBlur_t  in  1  deblur switch
  en_IGR_Rst_Func  in  1  enables the reset combo
  en_IGR_DeBl_15b_Func  in  1  enables the deblur and 15-bit combos
  DRV_RST  out  1  system reset pulse
  n15bit_o  out  1  15-bit mode, active-low
  nDeBlur_o  out  1  deblur, active-low
  pad_data_o  out  16  last valid button word
  pad_valid_o  out  1  one-VCLK strobe marking a new button word

Function
REQ-003 Timing and synchronisation:
- A tick enable SHALL assert for one VCLK cycle every CLK_DIV VCLK cycles; no derived clock is used.
- All logic SHALL run on VCLK and advance only on ticks, except pad_valid_o.
REQ-004 CTRL_i SHALL be synchronised through a 3-flop history sampled on ticks; edges are detected from the two oldest taps.
REQ-005 Edge-interval counter wait_cnt (WAIT_W bits):
- clears on any edge;
- otherwise increments per tick and saturates at all-ones;
- saturation forces state IDLE.
REQ-006 Bit decoding:
- On a rising edge, the low time SHALL be latched from wait_cnt.
- On the next falling edge, bit = (low time < high time), i.e. a strictly longer high phase decodes as 1.
REQ-007 State machine, states IDLE, CMD, RESP:
- IDLE->CMD when wait_cnt saturates, with the bit count cleared.
- CMD collects 8 bits, MSB first. On the ninth falling edge, go to RESP if the byte equals 8'h01, else go to IDLE.
- RESP collects 16 bits, LSB first, so A lands at bit 0. On the 17th falling edge, the word is complete and the FSM goes to IDLE.
- Any other encoding goes to IDLE.
REQ-008 On word completion, pad_data_o SHALL load the word, and pad_valid_o SHALL pulse high for exactly one VCLK on the same tick.
REQ-009 Hold counter (4 bits, saturating at HOLD_POLLS):
- increments when the word equals the previous valid word;
- otherwise reloads to 1.
- A combo fires exactly once, on the poll where the count reaches HOLD_POLLS.
- It does not re-fire until a different word resets the count.
REQ-010 Combo actions on firing:
- IGR_15B_ON/IGR_15B_OFF set n15bit_o to 0/1; gated by en_IGR_DeBl_15b_Func.
- IGR_DEBLUR_ON/IGR_DEBLUR_OFF set nDeBlur_o to 0/1; gated by en_IGR_DeBl_15b_Func and ignored while n64_480i=1.
- IGR_RESET starts the reset pulse; gated by en_IGR_Rst_Func.
REQ-011 A change on n15bit_mode_t or nVIDeBlur_t, detected via a 2-tap tick history, SHALL copy the switch to its output. On the same tick, this takes priority over a combo.
REQ-012 Reset pulse:
- Firing loads the reset counter with RST_LEN and sets DRV_RST=1.
- The counter decrements per tick; DRV_RST=0 on the tick after it reaches 0.
- Refiring mid-pulse reloads the counter to RST_LEN.
REQ-013 Abort rule: a saturated wait_cnt during CMD or RESP SHALL discard the partial word without pad_valid_o and without a combo.

Reset
REQ-014 While RST=1 (asynchronous):
- state=IDLE, wait_cnt=0, ctrl history=3'b111, hold count=0;
- pad_data_o=0, pad_valid_o=0, DRV_RST=0, reset counter=0;
- n15bit_o=1, nDeBlur_o=1, tick divider=0.
REQ-015 On the first tick after RST falls, n15bit_o and nDeBlur_o SHALL load their switch inputs, and both switch histories SHALL preload from the switches.
REQ-016 RST mid-frame or mid-pulse SHALL abandon the frame and end DRV_RST immediately.

Verification
REQ-017 Valid poll: idle >63 ticks, command 8'h01, response 16'h0001 -> pad_data_o=16'h0001, one pad_valid_o pulse, no output changes.
REQ-018 HOLD_POLLS=2: two consecutive IGR_15B_ON polls with enable=1 -> n15bit_o 1->0 on the second poll only; a third identical poll -> no further action.
REQ-019 Deblur combo with n64_480i=1 -> nDeBlur_o unchanged; the same with n64_480i=0 -> nDeBlur_o=0.
REQ-020 IGR_RESET held 2 polls with en_IGR_Rst_Func=1 -> DRV_RST=1 for RST_LEN+1 ticks, then 0; with enable=0 -> DRV_RST stays 0.
REQ-021 CTRL_i held low >63 ticks after 5 response bits -> return to IDLE, no pad_valid_o; the next full frame decodes correctly.
REQ-022 Toggle n15bit_mode_t on the same tick that an IGR_15B_ON combo fires -> n15bit_o follows the switch.

Source files
------------

// File: rtl/n64rgb_igr_if.sv
// Decoded controller button word handed from the IGR decoder to its consumers.
interface n64rgb_igr_if;
  // pad_valid_o is a one-cycle strobe with no back-pressure (no ready).
  // pad_data_o changes only on the strobe cycle and holds until the next one.
  logic [15:0] pad_data_o;
  logic        pad_valid_o;

  modport master (output pad_data_o, output pad_valid_o);
  modport slave  (input  pad_data_o, input  pad_valid_o);
endinterface

// File: rtl/n64rgb_igr.sv
// In-game routine: decodes N64 controller polls seen on CTRL_i and turns held
// button combos into 15-bit/deblur mode changes and a system reset pulse.
module n64rgb_igr #(
  parameter int unsigned CLK_DIV        = 6,
  parameter int unsigned WAIT_W         = 6,
  parameter int unsigned HOLD_POLLS     = 2,
  parameter logic [17:0] RST_LEN        = 18'h3ffff,
  parameter logic [15:0] IGR_RESET      = 16'h0C0F,
  parameter logic [15:0] IGR_DEBLUR_ON  = 16'h880C,
  parameter logic [15:0] IGR_DEBLUR_OFF = 16'h480C,
  parameter logic [15:0] IGR_15B_ON     = 16'h180C,
  parameter logic [15:0] IGR_15B_OFF    = 16'h280C
) (
  input  logic         VCLK,
  input  logic         RST,
  input  logic         CTRL_i,
  input  logic         n64_480i,
  input  logic         n15bit_mode_t,
  input  logic         nVIDeBlur_t,
  input  logic         en_IGR_Rst_Func,
  input  logic         en_IGR_DeBl_15b_Func,
  output logic         DRV_RST,
  output logic         n15bit_o,
  output logic         nDeBlur_o,
  n64rgb_igr_if.master pad,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_POLLS);

  state_t            state, state_nxt;
  logic [7:0]        div_cnt;
  logic              tick;
  logic [2:0]        ctrl_hist;
  logic              rise, fall, sat, bit_val;
  logic [WAIT_W-1:0] wait_cnt, low_time;
  logic [4:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        cmd_sr, cmd_sr_nxt;
  logic [14:0]       word_sr, word_sr_nxt;
  logic [15:0]       resp_word;
  logic              done, same, fire;
  logic [3:0]        hold, hold_nxt;
  logic [1:0]        sw15_hist, swdb_hist;
  logic              init_done;
  logic [17:0]       rst_cnt;

  assign dbg_state = state;
  assign tick      = (div_cnt == 8'(CLK_DIV - 1));
  assign rise      = ~ctrl_hist[2] & ctrl_hist[1];
  assign fall      = ctrl_hist[2] & ~ctrl_hist[1];
  assign sat       = &wait_cnt;
  assign bit_val   = (low_time < wait_cnt);
  assign resp_word = {bit_val, word_sr};

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 8'd1;
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      ctrl_hist <= 3'b111;
      wait_cnt  <= '0;
      low_time  <= '0;
    end else if (tick) begin
      ctrl_hist <= {ctrl_hist[1:0], CTRL_i};
      if (rise | fall) wait_cnt <= '0;
      else if (!sat)   wait_cnt <= wait_cnt + WAIT_W'(1);
      if (rise) low_time <= wait_cnt;
    end
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      word_sr <= '0;
    end else if (tick) begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cmd_sr  <= cmd_sr_nxt;
      word_sr <= word_sr_nxt;
    end
  end

  // The first falling edge of each phase only opens bit 0 (or ends the stop
  // bit), so data is shifted in from the second edge onwards.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cmd_sr_nxt  = cmd_sr;
    word_sr_nxt = word_sr;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (sat) begin
          state_nxt   = CMD;
          bit_cnt_nxt = '0;
        end
      end
      CMD: begin
        if (fall) begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt != 5'd0) cmd_sr_nxt = {cmd_sr[5:0], bit_val};
          if (bit_cnt == 5'd8) begin
            state_nxt   = ({cmd_sr, bit_val} == 8'h01) ? RESP : IDLE;
            bit_cnt_nxt = '0;
          end
        end else if (sat && bit_cnt != 5'd0) begin
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (fall) begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt != 5'd0) word_sr_nxt = resp_word[15:1];
          if (bit_cnt == 5'd16) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (sat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A combo fires only on the poll that brings the count up to HOLD.
  assign same     = (resp_word == pad.pad_data_o);
  assign hold_nxt = !same ? 4'd1 : ((hold >= HOLD) ? HOLD : hold + 4'd1);
  assign fire     = done && (hold_nxt == HOLD) && !(same && hold == HOLD);

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      hold            <= '0;
      pad.pad_data_o  <= '0;
      pad.pad_valid_o <= 1'b0;
    end else begin
      pad.pad_valid_o <= tick && done;
      if (tick && done) begin
        hold           <= hold_nxt;
        pad.pad_data_o <= resp_word;
      end
    end
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      n15bit_o  <= 1'b1;
      nDeBlur_o <= 1'b1;
      sw15_hist <= 2'b11;
      swdb_hist <= 2'b11;
      init_done <= 1'b0;
    end else if (tick) begin
      init_done <= 1'b1;
      sw15_hist <= init_done ? {sw15_hist[0], n15bit_mode_t} : {2{n15bit_mode_t}};
      swdb_hist <= init_done ? {swdb_hist[0], nVIDeBlur_t} : {2{nVIDeBlur_t}};
      if (!init_done)                    n15bit_o <= n15bit_mode_t;
      else if (sw15_hist[1] != sw15_hist[0]) n15bit_o <= sw15_hist[0];
      else if (fire && en_IGR_DeBl_15b_Func) begin
        if (resp_word == IGR_15B_ON)       n15bit_o <= 1'b0;
        else if (resp_word == IGR_15B_OFF) n15bit_o <= 1'b1;
      end
      if (!init_done)                    nDeBlur_o <= nVIDeBlur_t;
      else if (swdb_hist[1] != swdb_hist[0]) nDeBlur_o <= swdb_hist[0];
      else if (fire && en_IGR_DeBl_15b_Func && !n64_480i) begin
        if (resp_word == IGR_DEBLUR_ON)       nDeBlur_o <= 1'b0;
        else if (resp_word == IGR_DEBLUR_OFF) nDeBlur_o <= 1'b1;
      end
    end
  end

  // Pulse stays high for RST_LEN+1 ticks; refiring restarts it.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      DRV_RST <= 1'b0;
      rst_cnt <= '0;
    end else if (tick) begin
      if (fire && en_IGR_Rst_Func && resp_word == IGR_RESET) begin
        DRV_RST <= 1'b1;
        rst_cnt <= RST_LEN;
      end else if (DRV_RST) begin
        if (rst_cnt == 18'd0) DRV_RST <= 1'b0;
        else                  rst_cnt <= rst_cnt - 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_n64rgb_igr.sv
// Directed bench for n64rgb_igr: drives whole controller polls bit by bit and
// checks decoded words, combo effects and the reset pulse against a poll-level model.
module tb_n64rgb_igr;

  localparam int          CLK_DIV    = 4;
  localparam int          HOLD_POLLS = 2;
  localparam logic [17:0] RST_LEN    = 18'd20;
  localparam logic [15:0] W_RESET    = 16'h0C0F;
  localparam logic [15:0] W_DB_ON    = 16'h880C;
  localparam logic [15:0] W_DB_OFF   = 16'h480C;
  localparam logic [15:0] W_15_ON    = 16'h180C;
  localparam logic [15:0] W_15_OFF   = 16'h280C;

  logic VCLK = 1'b0;
  logic RST = 1'b0;
  logic CTRL_i = 1'b1;
  logic n64_480i = 1'b0;
  logic n15bit_mode_t = 1'b0;
  logic nVIDeBlur_t = 1'b1;
  logic en_IGR_Rst_Func = 1'b1;
  logic en_IGR_DeBl_15b_Func = 1'b1;
  logic DRV_RST, n15bit_o, nDeBlur_o;
  logic [1:0] dbg_state;

  n64rgb_igr_if pad ();

  n64rgb_igr #(.CLK_DIV(CLK_DIV), .HOLD_POLLS(HOLD_POLLS), .RST_LEN(RST_LEN)) dut (
    .VCLK                 (VCLK),
    .RST                  (RST),
    .CTRL_i               (CTRL_i),
    .n64_480i             (n64_480i),
    .n15bit_mode_t        (n15bit_mode_t),
    .nVIDeBlur_t          (nVIDeBlur_t),
    .en_IGR_Rst_Func      (en_IGR_Rst_Func),
    .en_IGR_DeBl_15b_Func (en_IGR_DeBl_15b_Func),
    .DRV_RST              (DRV_RST),
    .n15bit_o             (n15bit_o),
    .nDeBlur_o            (nDeBlur_o),
    .pad                  (pad),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 VCLK = ~VCLK;

  // ---------------- scoreboard / model state ----------------
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        settled = 1'b0;
  logic        m_n15 = 1'b1;
  logic        m_ndb = 1'b1;
  logic [15:0] last_word = 16'h0000;
  int          run_len = 0;
  int          exp_pulses = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  cmd_byte = 8'h01;
  int          hi_cnt = 0;
  int          pulses = 0;
  int          last_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Poll-level model: a run of identical words fires on the HOLD_POLLS-th poll only.
  task automatic model_word(input logic [15:0] w, input bit tog15);
    if (w == last_word) run_len++;
    else run_len = 1;
    last_word = w;
    if (run_len == HOLD_POLLS) begin
      if (en_IGR_DeBl_15b_Func) begin
        if (w == W_15_ON)  m_n15 = 1'b0;
        if (w == W_15_OFF) m_n15 = 1'b1;
        if (!n64_480i && w == W_DB_ON)  m_ndb = 1'b0;
        if (!n64_480i && w == W_DB_OFF) m_ndb = 1'b1;
      end
      if (en_IGR_Rst_Func && w == W_RESET) exp_pulses++;
    end
    if (tog15) m_n15 = n15bit_mode_t;
  endtask

  // ---------------- driver tasks ----------------
  task automatic ticks(input int n);
    repeat (n * CLK_DIV) @(negedge VCLK);
  endtask

  task automatic send_bit(input logic b);
    CTRL_i = 1'b0;
    ticks(b ? 1 : 3);
    CTRL_i = 1'b1;
    ticks(b ? 3 : 1);
  endtask

  task automatic set_sw(input logic s15, input logic sdb);
    settled = 1'b0;
    if (s15 != n15bit_mode_t) m_n15 = s15;
    if (sdb != nVIDeBlur_t)   m_ndb = sdb;
    n15bit_mode_t = s15;
    nVIDeBlur_t   = sdb;
    ticks(4);
    settled = 1'b1;
  endtask

  // nbits < 16 drops the line low mid-response to force a timeout.
  task automatic poll(input logic [15:0] w, input int nbits, input bit tog15);
    settled = 1'b0;
    CTRL_i = 1'b1;
    ticks(80);
    for (int i = 7; i >= 0; i--) send_bit(cmd_byte[i]);
    CTRL_i = 1'b0;
    ticks(1);
    CTRL_i = 1'b1;
    ticks(3);
    if (nbits == 16) exp_q.push_back(w);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
    if (nbits == 16) begin
      CTRL_i = 1'b0;
      ticks(1);
      if (tog15) n15bit_mode_t = ~n15bit_mode_t;
      CTRL_i = 1'b1;
      ticks(12);
      model_word(w, tog15);
    end else begin
      CTRL_i = 1'b0;
      ticks(70);
      CTRL_i = 1'b1;
      ticks(4);
    end
    check("poll_drained", exp_q.size(), 0);
    settled = 1'b1;
  endtask

  task automatic wait_drv_low();
    for (int i = 0; i < 2000 && DRV_RST; i++) @(negedge VCLK);
    check("drv_fell", DRV_RST, 1'b0);
    ticks(1);
  endtask

  // ---------------- compare process ----------------
  always @(negedge VCLK) begin
    if (!RST) begin
      if (pad.pad_valid_o) begin
        check("valid_width", prev_valid, 1'b0);
        check("valid_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("pad_data", pad.pad_data_o, exp_q.pop_front());
      end
      if (settled) begin
        check("n15bit_o", n15bit_o, m_n15);
        check("nDeBlur_o", nDeBlur_o, m_ndb);
      end
    end
    prev_valid = pad.pad_valid_o;
  end

  always @(negedge VCLK) begin
    if (DRV_RST) hi_cnt++;
    else if (hi_cnt != 0) begin
      pulses++;
      last_len = hi_cnt;
      hi_cnt = 0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    repeat (5) @(negedge VCLK);
    check("rst_drv", DRV_RST, 1'b0);
    check("rst_n15", n15bit_o, 1'b1);
    check("rst_ndb", nDeBlur_o, 1'b1);
    check("rst_valid", pad.pad_valid_o, 1'b0);
    check("rst_data", pad.pad_data_o, 16'h0000);

    RST = 1'b0;
    ticks(3);
    m_n15 = 1'b0;
    m_ndb = 1'b1;
    check("init_n15_lit", n15bit_o, 1'b0);
    settled = 1'b1;
    set_sw(1'b1, 1'b1);
    check("sw_n15_lit", n15bit_o, 1'b1);

    poll(16'h0001, 16, 0);
    check("valid_word_lit", pad.pad_data_o, 16'h0001);
    check("valid_n15_lit", n15bit_o, 1'b1);
    check("valid_ndb_lit", nDeBlur_o, 1'b1);

    poll(W_15_ON, 16, 0);
    check("15b_first_lit", n15bit_o, 1'b1);
    poll(W_15_ON, 16, 0);
    check("15b_second_lit", n15bit_o, 1'b0);
    set_sw(1'b0, 1'b1);
    set_sw(1'b1, 1'b1);
    poll(W_15_ON, 16, 0);
    check("15b_third_lit", n15bit_o, 1'b1);

    poll(16'h0001, 16, 0);
    n64_480i = 1'b1;
    poll(W_DB_ON, 16, 0);
    poll(W_DB_ON, 16, 0);
    check("db_480i_lit", nDeBlur_o, 1'b1);
    n64_480i = 1'b0;
    poll(16'h0001, 16, 0);
    poll(W_DB_ON, 16, 0);
    poll(W_DB_ON, 16, 0);
    check("db_on_lit", nDeBlur_o, 1'b0);
    poll(W_DB_OFF, 16, 0);
    poll(W_DB_OFF, 16, 0);
    check("db_off_lit", nDeBlur_o, 1'b1);

    poll(16'h5A3C, 5, 0);
    poll(16'h1234, 16, 0);
    check("after_abort_lit", pad.pad_data_o, 16'h1234);

    set_sw(1'b0, 1'b1);
    poll(W_15_ON, 16, 0);
    poll(W_15_ON, 16, 1);
    check("sw_priority_lit", n15bit_o, 1'b1);

    set_sw(1'b0, 1'b1);
    en_IGR_DeBl_15b_Func = 1'b0;
    poll(W_15_OFF, 16, 0);
    poll(W_15_OFF, 16, 0);
    check("15b_gated_lit", n15bit_o, 1'b0);
    en_IGR_DeBl_15b_Func = 1'b1;

    en_IGR_Rst_Func = 1'b1;
    poll(W_RESET, 16, 0);
    check("drv_first_poll_lit", DRV_RST, 1'b0);
    poll(W_RESET, 16, 0);
    check("drv_on_lit", DRV_RST, 1'b1);
    wait_drv_low();
    check("drv_len_lit", last_len, (RST_LEN + 1) * CLK_DIV);
    check("drv_count_lit", pulses, 1);
    check("drv_count", pulses, exp_pulses);

    poll(16'h0001, 16, 0);
    en_IGR_Rst_Func = 1'b0;
    poll(W_RESET, 16, 0);
    poll(W_RESET, 16, 0);
    check("drv_gated_lit", DRV_RST, 1'b0);
    ticks(5);
    check("drv_gated_count", pulses, exp_pulses);

    poll(16'h0001, 16, 0);
    en_IGR_Rst_Func = 1'b1;
    poll(W_RESET, 16, 0);
    poll(W_RESET, 16, 0);
    check("drv_refire_lit", DRV_RST, 1'b1);
    settled = 1'b0;
    RST = 1'b1;
    #1;
    check("drv_async_clear", DRV_RST, 1'b0);
    check("data_async_clear", pad.pad_data_o, 16'h0000);
    check("n15_async_set", n15bit_o, 1'b1);
    ticks(2);
    RST = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
